ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single-port program/data RAM between two requesters: the CPU control sequencer (port `c_`) and the UART program loader (port `l_`). Each accepted request runs as one fixed four-state RAM transaction: address latch, access, capture, then back to idle. Grants alternate round-robin when both ports are requesting. The block sits between the requesters and the `ram` instance and drives that instance's `addr_enable`, `write_enable`, `enable` and `bus_in`.

## Interface
- `WIDTH`, 8, data width of RAM words and of `ram_din`/`ram_dout`.
- `ADDRESS_WIDTH`, 4, RAM address width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `c_req`, `l_req`  in  1  request; held high until the matching `done`.
- `c_we`, `l_we`  in  1  1 = write, 0 = read; stable while `req` is high.
- `c_addr`, `l_addr`  in  ADDRESS_WIDTH  word address; stable while `req` is high.
- `c_wdata`, `l_wdata`  in  WIDTH  write data; stable while `req` is high.
- `c_gnt`, `l_gnt`  out  1  port owns the RAM (ADDR through CAPTURE).
- `c_done`, `l_done`  out  1  one-cycle transaction-complete pulse.
- `c_rdata`, `l_rdata`  out  WIDTH  read result; holds until that port's next read completes.
- `ram_addr_en`, `ram_we`, `ram_en`  out  1  to RAM `addr_enable`, `write_enable`, `enable`.
- `ram_din`  out  WIDTH  to RAM `bus_in`.
- `ram_dout`  in  WIDTH  from RAM `bus_out`.

## Operation
- States:
  - IDLE → ADDR, when a port is eligible.
  - ADDR → ACCESS.
  - ACCESS → CAPTURE.
  - CAPTURE → IDLE.
- Eligibility (evaluated in IDLE): `req & ~done` per port. The port whose `done` is high this cycle is ignored, so its still-high `req` is not re-accepted.
- Pick:
  - Only one port eligible: grant that port.
  - Both eligible: grant the port not served last.
  - `last` resets to CPU, so the loader wins the first tie after reset.
  - `last` updates on entry to ADDR.
- The winner's `we`, `addr` and `wdata` are latched on entry to ADDR. Later changes on that port's inputs have no effect on the transaction in flight.
- ADDR: `ram_addr_en`=1; `ram_din` = latched address zero-extended (upper WIDTH-ADDRESS_WIDTH bits 0).
- ACCESS:
  - Write: `ram_we`=1, `ram_din`=latched wdata.
  - Read: `ram_en`=1, `ram_din`=0.
- CAPTURE:
  - `ram_dout` is valid in this cycle.
  - For a read, the granted port's `rdata` register loads `ram_dout` at the end of CAPTURE.
  - `done` for the granted port is set for the following cycle.
- Outside the cycles above: all `ram_*` strobes are 0 and `ram_din`=0. At most one of `ram_addr_en`, `ram_we`, `ram_en` is high in any cycle.
- `gnt` is one-hot or zero; it is never high for both ports.
- A requester dropping `req` mid-transaction does not abort it; the transaction completes and `done` still pulses.
- `rstn` low, asynchronous, including mid-transaction:
  - State to IDLE, `last`=CPU.
  - All outputs 0, including `rdata`.
  - An interrupted RAM write may leave the target word undefined.

## Timing
- All outputs are registered.
- Single request sampled in IDLE at cycle 0:
  - `gnt`+`ram_addr_en` in cycle 1.
  - `ram_we`/`ram_en` in cycle 2.
  - CAPTURE in cycle 3.
  - `done` and valid `rdata` in cycle 4.
- Latency from `req` to `done` is 4 cycles; `gnt` is high for cycles 1–3.
- The cycle in which `done` is high is also an IDLE cycle, so the other port can start in that same cycle. Back-to-back throughput is one transaction per 4 cycles.
- With both ports requesting continuously, grants alternate strictly and each port completes one transaction per 8 cycles.

## Structure
- Shared package `bbcpu_pkg`:
  - State encoding: IDLE=0, ADDR=1, ACCESS=2, CAPTURE=3.
  - Port index constants: REQ_CPU=0, REQ_LDR=1.
- One sub-module, `rr_arbiter2`: a combinational two-input round-robin pick from `{eligible[1:0], last}`, returning a one-hot grant. The FSM, latches and output registers stay in `ram_arbiter`.

## Test plan
- Reset: hold `rstn`=0 with both `req`=1 → all outputs 0. Release → loader granted first (`l_gnt`=1 in cycle 1).
- CPU write then read: `c_req`, `c_we`=1, `c_addr`=4'hA, `c_wdata`=8'h5C → `ram_addr_en` with `ram_din`=8'h0A, then `ram_we` with `ram_din`=8'h5C, then `c_done` in cycle 4. A read of 4'hA → `c_rdata`=8'h5C when `c_done` is high.
- Contention: both ports request continuously → grants alternate L,C,L,C; each `done` is exactly 4 cycles after its grant's IDLE cycle; never both `gnt` high.
- Held `req` after `done`: CPU keeps `c_req`=1 one extra cycle with the loader idle → no second CPU grant in the `done` cycle; the next grant starts in the following IDLE cycle.
- Mid-transaction reset: assert `rstn`=0 during ACCESS of a loader write → outputs 0 immediately. After release, a CPU read completes normally with correct `c_rdata` and no spurious `l_done`.
- Input change after grant: change `c_addr` from 4'h3 to 4'h7 during ACCESS → the RAM sees address 4'h3; the read returns word 3.

Source files
------------

// File: rtl/bbcpu_pkg.sv
// rtl/bbcpu_pkg.sv - shared state encoding and requester indices for the RAM arbiter
package bbcpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        ACCESS  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_LDR = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-input round-robin pick, one-hot grant
module rr_arbiter2 (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic [1:0] grant
);

    // last: 0 = CPU served last, 1 = loader served last; a tie goes to the other one
    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the single-port RAM between CPU sequencer and UART loader
module ram_arbiter
    import bbcpu_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     c_req,
    input  logic                     c_we,
    input  logic [ADDRESS_WIDTH-1:0] c_addr,
    input  logic [WIDTH-1:0]         c_wdata,
    input  logic                     l_req,
    input  logic                     l_we,
    input  logic [ADDRESS_WIDTH-1:0] l_addr,
    input  logic [WIDTH-1:0]         l_wdata,
    output logic                     c_gnt,
    output logic                     c_done,
    output logic [WIDTH-1:0]         c_rdata,
    output logic                     l_gnt,
    output logic                     l_done,
    output logic [WIDTH-1:0]         l_rdata,
    output logic                     ram_addr_en,
    output logic                     ram_we,
    output logic                     ram_en,
    output logic [WIDTH-1:0]         ram_din,
    input  logic [WIDTH-1:0]         ram_dout
);

    state_t                   state;
    logic                     last;
    logic                     sel_ldr;
    logic                     lat_we;
    logic [WIDTH-1:0]         lat_wdata;
    logic [1:0]               eligible;
    logic [1:0]               pick;
    logic [ADDRESS_WIDTH-1:0] pick_addr;

    // A port whose done is showing this cycle must not be re-accepted on its still-high req
    assign eligible[REQ_CPU] = c_req & ~c_done;
    assign eligible[REQ_LDR] = l_req & ~l_done;
    assign pick_addr         = pick[REQ_LDR] ? l_addr : c_addr;

    rr_arbiter2 u_pick (
        .eligible (eligible),
        .last     (last),
        .grant    (pick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            last        <= 1'b0;
            sel_ldr     <= 1'b0;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
            c_gnt       <= 1'b0;
            l_gnt       <= 1'b0;
            c_done      <= 1'b0;
            l_done      <= 1'b0;
            c_rdata     <= '0;
            l_rdata     <= '0;
            ram_addr_en <= 1'b0;
            ram_we      <= 1'b0;
            ram_en      <= 1'b0;
            ram_din     <= '0;
        end else begin
            c_done      <= 1'b0;
            l_done      <= 1'b0;
            ram_addr_en <= 1'b0;
            ram_we      <= 1'b0;
            ram_en      <= 1'b0;
            ram_din     <= '0;
            case (state)
                IDLE: begin
                    if (|pick) begin
                        state       <= ADDR;
                        sel_ldr     <= pick[REQ_LDR];
                        last        <= pick[REQ_LDR];
                        c_gnt       <= pick[REQ_CPU];
                        l_gnt       <= pick[REQ_LDR];
                        lat_we      <= pick[REQ_LDR] ? l_we : c_we;
                        lat_wdata   <= pick[REQ_LDR] ? l_wdata : c_wdata;
                        ram_addr_en <= 1'b1;
                        ram_din     <= {{(WIDTH-ADDRESS_WIDTH){1'b0}}, pick_addr};
                    end
                end
                ADDR: begin
                    state <= ACCESS;
                    if (lat_we) begin
                        ram_we  <= 1'b1;
                        ram_din <= lat_wdata;
                    end else begin
                        ram_en <= 1'b1;
                    end
                end
                ACCESS: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    state <= IDLE;
                    c_gnt <= 1'b0;
                    l_gnt <= 1'b0;
                    if (sel_ldr) begin
                        l_done <= 1'b1;
                        if (!lat_we) l_rdata <= ram_dout;
                    end else begin
                        c_done <= 1'b1;
                        if (!lat_we) c_rdata <= ram_dout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       c_req, c_we, l_req, l_we;
    logic [3:0] c_addr, l_addr;
    logic [7:0] c_wdata, l_wdata;
    logic       c_gnt, c_done, l_gnt, l_done;
    logic [7:0] c_rdata, l_rdata;
    logic       ram_addr_en, ram_we, ram_en;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = 8'h00;

    int errors = 0;
    int checks = 0;

    ram_arbiter #(.WIDTH(8), .ADDRESS_WIDTH(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .c_req       (c_req),
        .c_we        (c_we),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata),
        .l_req       (l_req),
        .l_we        (l_we),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .c_gnt       (c_gnt),
        .c_done      (c_done),
        .c_rdata     (c_rdata),
        .l_gnt       (l_gnt),
        .l_done      (l_done),
        .l_rdata     (l_rdata),
        .ram_addr_en (ram_addr_en),
        .ram_we      (ram_we),
        .ram_en      (ram_en),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: unwritten words read as 8'hA0 + address
    logic [7:0] mem [16];
    bit   [15:0] written;
    logic [3:0] mar = 4'h0;
    always @(posedge clk) begin
        if (ram_addr_en) mar <= ram_din[3:0];
        if (ram_we) begin
            mem[mar]     <= ram_din;
            written[mar] <= 1'b1;
        end
        if (ram_en) ram_dout <= written[mar] ? mem[mar] : (8'hA0 + {4'h0, mar});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            chk("gnt_exclusive", 32'(c_gnt & l_gnt), 32'd0);
            chk("strobe_onehot0", 32'(32'(ram_addr_en) + 32'(ram_we) + 32'(ram_en) <= 1), 32'd1);
        end
    end

    initial begin
        rstn = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 4'h1; c_wdata = 8'h00;
        l_req = 1'b1; l_we = 1'b0; l_addr = 4'h5; l_wdata = 8'h00;

        // Reset with both requesting
        repeat (2) @(negedge clk);
        chk("rst_c_gnt", 32'(c_gnt), 0);
        chk("rst_l_gnt", 32'(l_gnt), 0);
        chk("rst_dones", 32'({c_done, l_done}), 0);
        chk("rst_strobes", 32'({ram_addr_en, ram_we, ram_en}), 0);
        chk("rst_din", 32'(ram_din), 0);
        chk("rst_rdata", 32'({c_rdata, l_rdata}), 0);
        rstn = 1'b1;

        // First tie after reset goes to the loader
        @(negedge clk);
        chk("first_l_gnt", 32'(l_gnt), 1);
        chk("first_c_gnt", 32'(c_gnt), 0);
        chk("first_addr_en", 32'(ram_addr_en), 1);
        chk("first_din", 32'(ram_din), 32'h05);
        c_req = 1'b0;
        @(negedge clk);
        chk("first_ram_en", 32'(ram_en), 1);
        chk("first_din_rd", 32'(ram_din), 0);
        @(negedge clk);
        chk("first_capture_gnt", 32'(l_gnt), 1);
        @(negedge clk);
        chk("first_l_done", 32'(l_done), 1);
        chk("first_l_rdata", 32'(l_rdata), 32'hA5);
        chk("first_gnt_off", 32'(l_gnt), 0);
        l_req = 1'b0;
        @(negedge clk);
        chk("first_done_pulse", 32'(l_done), 0);

        // CPU write 5C to A
        c_req = 1'b1; c_we = 1'b1; c_addr = 4'hA; c_wdata = 8'h5C;
        @(negedge clk);
        chk("wr_c_gnt", 32'(c_gnt), 1);
        chk("wr_addr_en", 32'(ram_addr_en), 1);
        chk("wr_din_addr", 32'(ram_din), 32'h0A);
        @(negedge clk);
        chk("wr_ram_we", 32'(ram_we), 1);
        chk("wr_addr_en_off", 32'(ram_addr_en), 0);
        chk("wr_din_data", 32'(ram_din), 32'h5C);
        @(negedge clk);
        chk("wr_no_early_done", 32'(c_done), 0);
        chk("wr_capture_din", 32'(ram_din), 0);
        @(negedge clk);
        chk("wr_c_done", 32'(c_done), 1);
        c_req = 1'b0;

        // CPU read of A, req held one cycle past done
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0;
        @(negedge clk);
        chk("rd_c_gnt", 32'(c_gnt), 1);
        @(negedge clk);
        chk("rd_ram_en", 32'(ram_en), 1);
        @(negedge clk);
        @(negedge clk);
        chk("rd_c_done", 32'(c_done), 1);
        chk("rd_c_rdata", 32'(c_rdata), 32'h5C);
        @(negedge clk);
        chk("held_no_regrant", 32'(c_gnt), 0);
        chk("held_done_off", 32'(c_done), 0);
        @(negedge clk);
        chk("held_next_gnt", 32'(c_gnt), 1);
        c_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_still_done", 32'(c_done), 1);
        chk("drop_rdata", 32'(c_rdata), 32'h5C);

        // Contention: last served CPU, so L,C,L,C
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 4'h3;
        l_req = 1'b1; l_we = 1'b0; l_addr = 4'h6;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cont_l_gnt", 32'(l_gnt), 32'(k % 2 == 0));
            chk("cont_c_gnt", 32'(c_gnt), 32'(k % 2 == 1));
            repeat (2) @(negedge clk);
            chk("cont_no_early_done", 32'({c_done, l_done}), 0);
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("cont_l_done", 32'({c_done, l_done}), 32'b01);
                chk("cont_l_rdata", 32'(l_rdata), 32'hA6);
            end else begin
                chk("cont_c_done", 32'({c_done, l_done}), 32'b10);
                chk("cont_c_rdata", 32'(c_rdata), 32'hA3);
            end
        end
        c_req = 1'b0; l_req = 1'b0;

        // Reset during ACCESS of a loader write
        @(negedge clk);
        l_req = 1'b1; l_we = 1'b1; l_addr = 4'h9; l_wdata = 8'hFF;
        @(negedge clk);
        chk("mr_l_gnt", 32'(l_gnt), 1);
        @(negedge clk);
        chk("mr_ram_we", 32'(ram_we), 1);
        #2 rstn = 1'b0;
        #1;
        chk("mr_gnt_off", 32'({c_gnt, l_gnt}), 0);
        chk("mr_strobes_off", 32'({ram_addr_en, ram_we, ram_en}), 0);
        chk("mr_din_off", 32'(ram_din), 0);
        chk("mr_rdata_off", 32'({c_rdata, l_rdata}), 0);
        l_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // CPU read of 3 with c_addr changed to 7 during ACCESS
        c_req = 1'b1; c_we = 1'b0; c_addr = 4'h3;
        @(negedge clk);
        chk("ac_c_gnt", 32'(c_gnt), 1);
        chk("ac_din_addr", 32'(ram_din), 32'h03);
        @(negedge clk);
        chk("ac_ram_en", 32'(ram_en), 1);
        c_addr = 4'h7;
        @(negedge clk);
        @(negedge clk);
        chk("ac_c_done", 32'(c_done), 1);
        chk("ac_c_rdata", 32'(c_rdata), 32'hA3);
        chk("ac_no_l_done", 32'(l_done), 0);
        c_req = 1'b0;
        @(negedge clk);
        chk("ac_done_off", 32'(c_done), 0);
        chk("ac_idle_gnt", 32'({c_gnt, l_gnt}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
